// File: rtl/i2s_tx_stream.sv
// Stereo I2S / left-justified transmitter for the PCM5102A path.
// BCK/LRCK come from clock enables in cmn_clk; {L,R} pairs are buffered in a FIFO and serialised MSB first.
module i2s_tx_stream #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned SLOT_W     = 32,
  parameter int unsigned HALF_DIV   = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          cmn_clk,
  input  logic                          cmn_rst_n,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic [2*DATA_W-1:0]           s_tdata,
  input  logic                          fmt_lj,
  input  logic                          mute,
  output logic                          dac_bck,
  output logic                          dac_lrck,
  output logic                          dac_din,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun
);

  localparam int unsigned PAIR_W = 2 * DATA_W;
  localparam int unsigned BIT_W  = $clog2(2 * SLOT_W);
  localparam int unsigned DIV_W  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;

  if (SLOT_W < DATA_W + 1) begin : g_bad_slot
    $error("i2s_tx_stream: SLOT_W must be >= DATA_W+1");
  end
  if (HALF_DIV < 1) begin : g_bad_div
    $error("i2s_tx_stream: HALF_DIV must be >= 1");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("i2s_tx_stream: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [DIV_W-1:0]  r_div_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_bck;
  logic              r_lrck;
  logic              r_din;
  logic              r_underrun;
  logic              r_fmt_lj;
  logic [PAIR_W-1:0] r_word;
  logic [PAIR_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_tready;

  logic              w_div_wrap;
  logic              w_fe;
  logic [BIT_W-1:0]  w_bit_nxt;
  logic              w_frame_start;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [LVL_W-1:0]  w_level_nxt;
  logic [PAIR_W-1:0] w_word_nxt;
  logic              w_lj;
  logic              w_in_left;
  logic [BIT_W-1:0]  w_pos;
  logic [DATA_W-1:0] w_slot_word;
  logic              w_in_rng;
  logic [BIT_W-1:0]  w_shamt;
  logic              w_din_nxt;

  assign w_div_wrap    = (r_div_cnt == DIV_W'(HALF_DIV - 1));
  assign w_fe          = w_div_wrap & r_bck;
  assign w_bit_nxt     = (r_bit_cnt == BIT_W'(2 * SLOT_W - 1)) ? '0 : r_bit_cnt + BIT_W'(1);
  assign w_frame_start = w_fe & (w_bit_nxt == '0);
  assign w_empty       = (r_level == '0);
  assign w_push        = s_tvalid & r_tready;
  assign w_pop         = w_frame_start & ~w_empty;
  assign w_level_nxt   = r_level + LVL_W'(w_push) - LVL_W'(w_pop);

  // The popped word (or zero when muted/empty) drives bit 0 of the new frame directly.
  assign w_word_nxt  = w_frame_start ? ((w_empty | mute) ? '0 : r_mem[r_rd_ptr]) : r_word;
  assign w_lj        = w_frame_start ? fmt_lj : r_fmt_lj;
  assign w_in_left   = (w_bit_nxt < BIT_W'(SLOT_W));
  assign w_pos       = w_in_left ? w_bit_nxt : w_bit_nxt - BIT_W'(SLOT_W);
  assign w_slot_word = w_in_left ? w_word_nxt[PAIR_W-1:DATA_W] : w_word_nxt[DATA_W-1:0];

  // Bit select: shamt counts from the MSB; I2S starts one slot position later than LJ.
  always_comb begin
    w_in_rng  = 1'b0;
    w_shamt   = w_pos;
    w_din_nxt = 1'b0;
    if (w_lj) begin
      w_in_rng = (w_pos < BIT_W'(DATA_W));
      w_shamt  = w_pos;
    end else begin
      w_in_rng = (w_pos != '0) && (w_pos <= BIT_W'(DATA_W));
      w_shamt  = w_pos - BIT_W'(1);
    end
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (w_in_rng && (w_shamt == BIT_W'(i))) w_din_nxt = w_slot_word[DATA_W-1-i];
    end
  end

  // Clock-enable divider and serialiser; all DAC pins change together on the BCK falling event.
  always_ff @(posedge cmn_clk or negedge cmn_rst_n) begin
    if (!cmn_rst_n) begin
      r_div_cnt  <= '0;
      r_bck      <= 1'b0;
      r_bit_cnt  <= BIT_W'(2 * SLOT_W - 1);
      r_lrck     <= 1'b1;
      r_din      <= 1'b0;
      r_word     <= '0;
      r_fmt_lj   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_frame_start & w_empty;
      if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_bck     <= ~r_bck;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
      if (w_fe) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrck    <= ~w_in_left;
        r_din     <= w_din_nxt;
      end
      if (w_frame_start) begin
        r_word   <= w_word_nxt;
        r_fmt_lj <= fmt_lj;
      end
    end
  end

  // FIFO pointers, level and registered ready.
  always_ff @(posedge cmn_clk or negedge cmn_rst_n) begin
    if (!cmn_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_tready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level  <= w_level_nxt;
      r_tready <= (w_level_nxt < LVL_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge cmn_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_tdata;
  end

  assign s_tready   = r_tready;
  assign dac_bck    = r_bck;
  assign dac_lrck   = r_lrck;
  assign dac_din    = r_din;
  assign fifo_level = r_level;
  assign underrun   = r_underrun;

endmodule
